// File: rtl/conv_mxfp6tobf16.sv
// conv_mxfp6tobf16: decode one MXFP6 block plus shared scale into beats of bf16 lanes.
// Define MXFP6_DEC_SUBNORM_EN to keep E<=0 results as rounded bf16 subnormals instead of flushing them to zero.
module conv_mxfp6tobf16 #(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  parameter int bit_width = 1 + exp_width + man_width,
  parameter int k = 32,
  parameter int lanes = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [bit_width*k-1:0]   i_mx_vec,
  input  logic [7:0]               i_mx_exp,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [16*lanes-1:0]      o_bf16_vec,
  output logic                     o_last
);
  localparam int nbeat = k / lanes;
  localparam int bw_b = nbeat > 1 ? $clog2(nbeat) : 1;
  localparam int bias = 2 ** (exp_width - 1) - 1;

  if (k % lanes != 0) begin : g_bad_k
    $error("k must be a multiple of lanes");
  end
  if (man_width > 6) begin : g_bad_m
    $error("man_width must fit below the bf16 mantissa");
  end

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [bw_b-1:0] beat, beat_n, src_b;
  logic [bit_width*k-1:0] hold_vec, src_vec;
  logic [7:0] hold_s, src_s;
  logic [16*lanes-1:0] dec_vec;
  logic [bit_width-1:0] src_el [nbeat][lanes];
  logic accept, consume, last, load;

  function automatic logic [15:0] dec(input logic [bit_width-1:0] x, input logic [7:0] s);
    logic sg;
    logic [exp_width-1:0] e;
    logic [man_width-1:0] m, mn;
    logic signed [9:0] ee;
    logic [6:0] mt;
    int lz;
`ifdef MXFP6_DEC_SUBNORM_EN
    logic [9:0] sh;
    logic [15:0] full;
    logic [7:0] f;
`endif
    sg = x[bit_width-1];
    e = x[bit_width-2 -: exp_width];
    m = x[man_width-1:0];
    lz = 0;
    for (int i = 0; i < man_width; i++) if (m[i]) lz = man_width - 1 - i;
    mn = m << (lz + 1);
    ee = (e != '0) ? 10'(s) + 10'(e) - 10'(bias) : 10'(s) - 10'(bias) - 10'(lz);
    mt = 7'((e != '0) ? m : mn) << (7 - man_width);
    if (s == 8'hFF) return 16'h7FC0;
    if (e == '0 && m == '0) return {sg, 15'h0};
    if (ee >= 10'sd255) return {sg, 8'hFF, 7'h0};
`ifdef MXFP6_DEC_SUBNORM_EN
    if (ee <= 10'sd0) begin
      sh = 10'd1 - ee;
      full = {1'b1, mt, 8'h00} >> sh;
      f = full[15:8] + 8'(full[7] && (|full[6:0] || full[8]));
      return {sg, 7'h00, f};
    end
`else
    if (ee <= 10'sd0) return {sg, 15'h0};
`endif
    return {sg, ee[7:0], mt};
  endfunction

  always_comb begin
    o_valid = state == STREAM;
    last = beat == bw_b'(nbeat - 1);
    o_last = last && o_valid;
    o_ready = !o_valid || (i_ready && o_last);
    accept = i_valid && o_ready;
    consume = o_valid && i_ready;
    load = accept || (consume && !last);
    state_n = accept ? STREAM : (consume && last) ? IDLE : state;
    beat_n = accept ? '0 : (consume && !last) ? beat + 1'b1 : beat;
    src_vec = accept ? i_mx_vec : hold_vec;
    src_s = accept ? i_mx_exp : hold_s;
    src_b = accept ? '0 : beat + 1'b1;
  end

  for (genvar b = 0; b < nbeat; b++) begin : g_beat
    for (genvar j = 0; j < lanes; j++) begin : g_el
      assign src_el[b][j] = src_vec[bit_width*(b*lanes+j) +: bit_width];
    end
  end

  for (genvar j = 0; j < lanes; j++) begin : g_lane
    assign dec_vec[16*j +: 16] = dec(src_el[src_b][j], src_s);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      beat <= '0;
      o_bf16_vec <= '0;
      hold_vec <= '0;
      hold_s <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      if (load) o_bf16_vec <= dec_vec;
      if (accept) begin
        hold_vec <= i_mx_vec;
        hold_s <= i_mx_exp;
      end
    end
  end
endmodule

// File: tb/tb_conv_mxfp6tobf16.sv
// tb_conv_mxfp6tobf16: directed checks of the MXFP6 block to bf16 beat decoder.
module tb_conv_mxfp6tobf16;
  logic clk, rst, valid, ready_in, o_ready, o_valid, o_last;
  logic [191:0] vec;
  logic [7:0] s_in;
  logic [127:0] o_bf16_vec;
  int checks, failures;

  conv_mxfp6tobf16 dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_mx_vec(vec), .i_mx_exp(s_in), .o_valid(o_valid), .i_ready(ready_in),
    .o_bf16_vec(o_bf16_vec), .o_last(o_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int idx, input logic [5:0] v);
    vec = vec | (192'(v) << (6 * idx));
  endtask

  task automatic load(input logic [7:0] sc);
    s_in = sc;
    valid = 1;
    tick();
    valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && o_valid; n++) tick();
    chk("drain_idle", 128'(o_valid), 128'(0));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk = 0;
    rst = 1;
    valid = 0;
    ready_in = 1;
    vec = '0;
    s_in = 0;
    repeat (2) tick();
    rst = 0;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_last", 128'(o_last), 128'(0));
    chk("rst_data", o_bf16_vec, 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    // Normal and element-subnormal decode, then a 3-cycle stall on beat 1
    vec = '0;
    put(0, 6'b0_011_00); put(1, 6'b0_111_11); put(2, 6'b1_010_10); put(3, 6'b0_000_00);
    put(8, 6'b0_000_01); put(9, 6'b1_000_10); put(10, 6'b0_111_00);
    put(16, 6'b0_001_00); put(24, 6'b1_000_11);
    load(127);
    chk("t1_valid", 128'(o_valid), 128'(1));
    chk("t1_beat0", o_bf16_vec, {64'h0, 16'h0000, 16'hBF40, 16'h41E0, 16'h3F80});
    chk("t1_last0", 128'(o_last), 128'(0));
    chk("t1_ready0", 128'(o_ready), 128'(0));
    tick();
    chk("t2_beat1", o_bf16_vec, {80'h0, 16'h4180, 16'hBE00, 16'h3D80});
    ready_in = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_stall_data", o_bf16_vec, {80'h0, 16'h4180, 16'hBE00, 16'h3D80});
      chk("t5_stall_ready", 128'(o_ready), 128'(0));
      chk("t5_stall_last", 128'(o_last), 128'(0));
    end
    ready_in = 1;
    tick();
    chk("t5_beat2", o_bf16_vec, {112'h0, 16'h3E80});
    chk("t5_last2", 128'(o_last), 128'(0));
    tick();
    chk("t5_beat3", o_bf16_vec, {112'h0, 16'hBE40});
    chk("t5_last3", 128'(o_last), 128'(1));
    chk("t5_ready3", 128'(o_ready), 128'(1));
    tick();
    chk("t5_four_beats", 128'(o_valid), 128'(0));
    // Overflow to Inf and largest finite result
    vec = '0;
    put(0, 6'b0_111_00); put(1, 6'b1_111_11); put(2, 6'b0_011_00);
    load(254);
    chk("t3_inf", o_bf16_vec, {80'h0, 16'h7F00, 16'hFF80, 16'h7F80});
    drain();
    // NaN block
    vec = '0;
    put(0, 6'b0_011_00); put(9, 6'b1_000_01);
    load(8'hFF);
    for (int b = 0; b < 4; b++) begin
      chk("t3_nan", o_bf16_vec, {8{16'h7FC0}});
      tick();
    end
    chk("t3_nan_done", 128'(o_valid), 128'(0));
    // Results at and below the normal range
    vec = '0;
    put(0, 6'b0_001_00); put(1, 6'b0_001_11); put(2, 6'b0_010_00);
    put(3, 6'b1_011_00); put(4, 6'b1_001_00);
    load(1);
`ifdef MXFP6_DEC_SUBNORM_EN
    chk("t4_s1", o_bf16_vec, {48'h0, 16'h8020, 16'h8080, 16'h0040, 16'h0038, 16'h0020});
`else
    chk("t4_s1", o_bf16_vec, {48'h0, 16'h8000, 16'h8080, 16'h0000, 16'h0000, 16'h0000});
`endif
    drain();
    vec = '0;
    put(0, 6'b0_000_01); put(1, 6'b1_111_11);
    load(0);
`ifdef MXFP6_DEC_SUBNORM_EN
    chk("t4_s0", o_bf16_vec, {96'h0, 16'h8260, 16'h0004});
`else
    chk("t4_s0", o_bf16_vec, {96'h0, 16'h8260, 16'h0000});
`endif
    drain();
    // Two back-to-back blocks with i_valid held high
    vec = '0;
    put(0, 6'b0_011_00); put(8, 6'b0_011_00); put(16, 6'b0_011_00); put(24, 6'b0_011_00);
    s_in = 127;
    valid = 1;
    tick();
    s_in = 128;
    for (int c = 0; c < 8; c++) begin
      chk("t6_valid", 128'(o_valid), 128'(1));
      chk("t6_lane0", 128'(o_bf16_vec[15:0]), c < 4 ? 128'h3F80 : 128'h4000);
      chk("t6_last", 128'(o_last), 128'(c % 4 == 3));
      chk("t6_ready", 128'(o_ready), 128'(c % 4 == 3));
      if (c == 4) valid = 0;
      tick();
    end
    chk("t6_idle", 128'(o_valid), 128'(0));
    // Reset in the middle of a block
    load(127);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t6_rst_valid", 128'(o_valid), 128'(0));
    chk("t6_rst_last", 128'(o_last), 128'(0));
    chk("t6_rst_data", o_bf16_vec, 128'(0));
    tick();
    chk("t6_rst_quiet", 128'(o_valid), 128'(0));
    load(128);
    for (int b = 0; b < 4; b++) begin
      chk("t6_fresh_valid", 128'(o_valid), 128'(1));
      chk("t6_fresh_lane0", 128'(o_bf16_vec[15:0]), 128'h4000);
      chk("t6_fresh_last", 128'(o_last), 128'(b == 3));
      tick();
    end
    chk("t6_fresh_done", 128'(o_valid), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
